// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter in front of the SPI core:
// grant-state encodings and SPI core register offsets for the master modules.
package wb_arb_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t IDLE = 2'b00;
   localparam arb_state_t GNT0 = 2'b01;
   localparam arb_state_t GNT1 = 2'b10;

   localparam logic [4:0] SPI_RXTX = 5'h00;
   localparam logic [4:0] SPI_CTRL = 5'h10;
   localparam logic [4:0] SPI_DIV  = 5'h14;
   localparam logic [4:0] SPI_SS   = 5'h18;

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall watchdog for the arbiter: counts owner strobe cycles without ack and
// flags expiry on the last allowed cycle (used only with WB_ARB_TIMEOUT_EN).
module wb_arb_timeout #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic CLK_48,
   input  logic rst_n,
   input  logic count_en,
   input  logic clear,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (count_en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Expiry is gated by count_en so a strobe dropped on the last cycle does not fire.
   assign expire = count_en && (cnt_q == CNT_MAX);

   always_ff @(posedge CLK_48 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_spi_arbiter.sv
// Two-master Wishbone arbiter with bus-hold lock in front of the SPI core.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
import wb_arb_pkg::*;

module wb_spi_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        CLK_48,
   input  logic        rst_n,
   // master 0
   input  logic        m0_cyc,
   input  logic        m0_stb,
   input  logic        m0_we,
   input  logic        m0_lock,
   input  logic [4:0]  m0_adr,
   input  logic [31:0] m0_di,
   input  logic [3:0]  m0_sel,
   output logic        m0_ack,
   output logic        m0_err,
   output logic        m0_int,
   output logic [31:0] m0_do,
   // master 1
   input  logic        m1_cyc,
   input  logic        m1_stb,
   input  logic        m1_we,
   input  logic        m1_lock,
   input  logic [4:0]  m1_adr,
   input  logic [31:0] m1_di,
   input  logic [3:0]  m1_sel,
   output logic        m1_ack,
   output logic        m1_err,
   output logic        m1_int,
   output logic [31:0] m1_do,
   // SPI core side
   output logic        s_cyc,
   output logic        s_stb,
   output logic        s_we,
   output logic [4:0]  s_adr,
   output logic [31:0] s_di,
   output logic [3:0]  s_sel,
   input  logic        s_ack,
   input  logic        s_err,
   input  logic        s_int,
   input  logic [31:0] s_do,
   // grant state for observation
   output logic [1:0]  dbg_state
);

   arb_state_t gnt_q;
   arb_state_t gnt_d;
   logic       last_gnt_q;
   logic       last_gnt_d;
   logic       req0;
   logic       req1;
   logic       own0;
   logic       own1;
   logic       expire;

   assign req0 = m0_cyc | m0_lock;
   assign req1 = m1_cyc | m1_lock;
   assign own0 = (gnt_q == GNT0);
   assign own1 = (gnt_q == GNT1);

   // A non-owner's lock only counts as a request; the owner's lock holds the grant.
   always_comb begin
      gnt_d      = gnt_q;
      last_gnt_d = last_gnt_q;
      case (gnt_q)
         IDLE: begin
            if (req0 && req1) begin
               gnt_d = last_gnt_q ? GNT0 : GNT1;
            end else if (req0) begin
               gnt_d = GNT0;
            end else if (req1) begin
               gnt_d = GNT1;
            end
         end
         GNT0: begin
            if (!req0 || expire) begin
               gnt_d      = req1 ? GNT1 : IDLE;
               last_gnt_d = 1'b0;
            end
         end
         GNT1: begin
            if (!req1 || expire) begin
               gnt_d      = req0 ? GNT0 : IDLE;
               last_gnt_d = 1'b1;
            end
         end
         default: gnt_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_48 or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q      <= IDLE;
         last_gnt_q <= 1'b1;
      end else begin
         gnt_q      <= gnt_d;
         last_gnt_q <= last_gnt_d;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   logic owner_stb;
   logic to_count_en;
   logic to_clear;

   assign owner_stb   = (own0 & m0_stb) | (own1 & m1_stb);
   assign to_count_en = owner_stb & ~s_ack;
   assign to_clear    = s_ack | (gnt_d != gnt_q);

   wb_arb_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .CLK_48  (CLK_48),
      .rst_n   (rst_n),
      .count_en(to_count_en),
      .clear   (to_clear),
      .expire  (expire)
   );
`else
   assign expire = 1'b0;
`endif

   // Reset forces IDLE asynchronously, so the IDLE defaults also cover reset.
   always_comb begin
      s_cyc = 1'b0;
      s_stb = 1'b0;
      s_we  = 1'b0;
      s_adr = '0;
      s_di  = '0;
      s_sel = '0;
      if (own0) begin
         s_cyc = m0_cyc & ~expire;
         s_stb = m0_stb & ~expire;
         s_we  = m0_we;
         s_adr = m0_adr;
         s_di  = m0_di;
         s_sel = m0_sel;
      end else if (own1) begin
         s_cyc = m1_cyc & ~expire;
         s_stb = m1_stb & ~expire;
         s_we  = m1_we;
         s_adr = m1_adr;
         s_di  = m1_di;
         s_sel = m1_sel;
      end
   end

   assign m0_ack = own0 & s_ack;
   assign m0_err = own0 & (s_err | expire);
   assign m0_int = own0 & s_int;
   assign m1_ack = own1 & s_ack;
   assign m1_err = own1 & (s_err | expire);
   assign m1_int = own1 & s_int;

   assign m0_do = s_do;
   assign m1_do = s_do;

   assign dbg_state = gnt_q;

endmodule

// File: tb/tb_wb_spi_arbiter.sv
// Directed bench for wb_spi_arbiter: expected master-side responses are queued
// by the stimulus and compared by a negedge monitor; grant/bus checks inline.
module tb_wb_spi_arbiter;
   import wb_arb_pkg::*;

   localparam int W = 70;
   localparam logic [5:0] F_ACK0 = 6'b000001;
   localparam logic [5:0] F_ERR0 = 6'b000010;
   localparam logic [5:0] F_INT0 = 6'b000100;
   localparam logic [5:0] F_ACK1 = 6'b001000;

   logic        CLK_48 = 1'b0;
   logic        rst_n;
   logic        m0_cyc, m0_stb, m0_we, m0_lock;
   logic [4:0]  m0_adr;
   logic [31:0] m0_di;
   logic [3:0]  m0_sel;
   logic        m0_ack, m0_err, m0_int;
   logic [31:0] m0_do;
   logic        m1_cyc, m1_stb, m1_we, m1_lock;
   logic [4:0]  m1_adr;
   logic [31:0] m1_di;
   logic [3:0]  m1_sel;
   logic        m1_ack, m1_err, m1_int;
   logic [31:0] m1_do;
   logic        s_cyc, s_stb, s_we;
   logic [4:0]  s_adr;
   logic [31:0] s_di;
   logic [3:0]  s_sel;
   logic        s_ack, s_err, s_int;
   logic [31:0] s_do;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];

   always #5 CLK_48 = ~CLK_48;

   wb_spi_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .CLK_48(CLK_48), .rst_n(rst_n),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_lock(m0_lock),
      .m0_adr(m0_adr), .m0_di(m0_di), .m0_sel(m0_sel),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_int(m0_int), .m0_do(m0_do),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_lock(m1_lock),
      .m1_adr(m1_adr), .m1_di(m1_di), .m1_sel(m1_sel),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_int(m1_int), .m1_do(m1_do),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_di(s_di), .s_sel(s_sel),
      .s_ack(s_ack), .s_err(s_err), .s_int(s_int), .s_do(s_do),
      .dbg_state(dbg_state)
   );

   function automatic logic [W-1:0] resp(input logic [5:0] flags, input logic [31:0] d);
      return {flags, d, d};
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK_48);
      #1;
   endtask

   task automatic clear_inputs();
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_lock = 0; m0_adr = '0; m0_di = '0; m0_sel = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_lock = 0; m1_adr = '0; m1_di = '0; m1_sel = '0;
      s_ack = 0; s_err = 0; s_int = 0; s_do = '0;
   endtask

   task automatic reset_dut();
      @(posedge CLK_48);
      #2 rst_n = 1'b0;
      clear_inputs();
      #10 rst_n = 1'b1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clear_inputs();
      rst_n = 1'b0;

      fork
         forever begin
            @(negedge CLK_48);
            if (|{m1_int, m1_err, m1_ack, m0_int, m0_err, m0_ack}) begin
               if (exp_q.size() == 0)
                  check("unexpected_resp", {m1_int, m1_err, m1_ack, m0_int, m0_err, m0_ack, m0_do, m1_do}, '0);
               else
                  check("resp", {m1_int, m1_err, m1_ack, m0_int, m0_err, m0_ack, m0_do, m1_do}, exp_q.pop_front());
            end
         end
      join_none

      // reset state and output gating
      #12;
      check("rst_state", dbg_state, IDLE);
      check("rst_bus", {s_cyc, s_stb, s_we, s_adr, s_di, s_sel}, '0);
      s_ack = 1; s_int = 1; s_err = 1;
      #1 check("rst_resp_gate", {m0_ack, m0_err, m0_int, m1_ack, m1_err, m1_int}, '0);
      s_ack = 0; s_int = 0; s_err = 0;
      #5 rst_n = 1'b1;

      // m0 write alone
      tick();
      m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = SPI_CTRL; m0_di = 32'h00003210; m0_sel = 4'hf;
      #1 check("idle_no_grant", {dbg_state, s_cyc}, {IDLE, 1'b0});
      tick();
      check("m0_gnt", dbg_state, GNT0);
      check("m0_bus", {s_cyc, s_stb, s_we, s_adr, s_di, s_sel}, {3'b111, 5'h10, 32'h00003210, 4'hf});
      s_do = 32'hcafe0001; s_ack = 1;
      exp_q.push_back(resp(F_ACK0, 32'hcafe0001));
      tick();
      s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
      tick();
      check("m0_release", dbg_state, IDLE);

      // simultaneous first requests, then alternation
      reset_dut();
      m0_cyc = 1; m0_stb = 1; m0_adr = SPI_DIV;
      m1_cyc = 1; m1_stb = 1; m1_adr = SPI_RXTX; m1_di = 32'h11;
      tick();
      check("both_first_gnt0", {dbg_state, s_adr}, {GNT0, SPI_DIV});
      s_do = 32'h0000a5a5; s_ack = 1;
      exp_q.push_back(resp(F_ACK0, 32'h0000a5a5));
      tick();
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      tick();
      check("handover_gnt1", {dbg_state, s_adr, s_di}, {GNT1, SPI_RXTX, 32'h11});
      s_do = 32'h5a5a0000; s_ack = 1;
      exp_q.push_back(resp(F_ACK1, 32'h5a5a0000));
      tick();
      s_ack = 0; m1_cyc = 0; m1_stb = 0;
      tick();
      check("idle_after_m1", dbg_state, IDLE);
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      tick();
      check("alternate_gnt0", dbg_state, GNT0);
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      tick();
      check("idle_after_alt", dbg_state, IDLE);

      // lock holds grant across cyc drops; other master's lock is only a request
      m0_lock = 1; m0_cyc = 1;
      tick();
      check("lock_gnt0", dbg_state, GNT0);
      m0_cyc = 0; m1_cyc = 1; m1_stb = 1; m1_lock = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("lock_hold", {dbg_state, s_cyc}, {GNT0, 1'b0});
         if (i == 2) begin
            s_int = 1;
            exp_q.push_back(resp(F_INT0, s_do));
         end else begin
            s_int = 0;
         end
      end
      m0_lock = 0;
      tick();
      check("lock_release_gnt1", {dbg_state, s_cyc}, {GNT1, 1'b1});
      m1_lock = 0; m1_cyc = 0; m1_stb = 0;
      tick();
      check("idle_after_lock", dbg_state, IDLE);

      // stalled owner
      m0_cyc = 1; m0_stb = 1; m0_lock = 1;
      tick();
      check("stall_gnt0", dbg_state, GNT0);
`ifdef WB_ARB_TIMEOUT_EN
      for (int i = 1; i < 15; i++) tick();
      check("stall_stb_high", {dbg_state, s_stb}, {GNT0, 1'b1});
      tick();
      exp_q.push_back(resp(F_ERR0, s_do));
      check("timeout_bus_low", {s_cyc, s_stb}, 2'b00);
      tick();
      check("timeout_release", dbg_state, IDLE);
`else
      for (int i = 0; i < 100; i++) tick();
      check("no_timeout_hold", {dbg_state, s_cyc, s_stb}, {GNT0, 2'b11});
`endif
      m0_cyc = 0; m0_stb = 0; m0_lock = 0;
      tick();
      tick();
      check("idle_after_stall", dbg_state, IDLE);

      // asynchronous reset mid-read
      m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = SPI_RXTX;
      tick();
      check("read_gnt1", {dbg_state, s_cyc, s_stb}, {GNT1, 2'b11});
      #2 rst_n = 1'b0;
      #1 check("async_rst_bus", {dbg_state, s_cyc, s_stb, s_adr}, '0);
      s_ack = 1;
      #3 s_ack = 0;
      rst_n = 1'b1;
      tick();
      check("post_rst_gnt1", dbg_state, GNT1);
      m1_cyc = 0; m1_stb = 0;
      tick();
      check("final_idle", dbg_state, IDLE);

      tick();
      tick();
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
